// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Result codes; CMP_NONE marks "no decision yet" / "no result presented".
    localparam logic [1:0] CMP_NONE = 2'd0;
    localparam logic [1:0] CMP_LT   = 2'd1;
    localparam logic [1:0] CMP_EQ   = 2'd2;
    localparam logic [1:0] CMP_GT   = 2'd3;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit index width, never below one bit so NDIG==1 still has a counter.
    function automatic int calc_idx_w(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_digit_compare.sv
// Combinational unsigned compare of one DIGIT-wide slice.
module digit_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    // Plain magnitude relation of the two slices.
    always_comb begin
        lt = (a < b);
        eq = (a == b);
        gt = (a > b);
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | stepping digits from MSB towards LSB
// DONE  | result presented, held until out_ready
module serial_magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             less,
    output logic             equal,
    output logic             greater,
    output logic             busy
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int IDX_W = calc_idx_w(NDIG);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NDIG - 1);

    if (DIGIT < 1 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_magnitude_comparator: WIDTH must be a positive multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       dec_q, dec_d;
    logic [1:0]       res_q, res_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0] slice_a, slice_b;
    logic             dig_lt, dig_eq, dig_gt;
    logic [1:0]       dig_code;
    logic [1:0]       decided;

    assign slice_a = a_q[int'(idx_q)*DIGIT +: DIGIT];
    assign slice_b = b_q[int'(idx_q)*DIGIT +: DIGIT];

    digit_compare #(.DIGIT(DIGIT)) u_digit (
        .a  (slice_a),
        .b  (slice_b),
        .lt (dig_lt),
        .eq (dig_eq),
        .gt (dig_gt)
    );

    // Current digit's verdict, and the sticky decision including earlier digits.
    always_comb begin
        dig_code = CMP_NONE;
        if (!dig_eq) begin
            dig_code = dig_lt ? CMP_LT : (dig_gt ? CMP_GT : CMP_NONE);
        end
        decided = (dec_q != CMP_NONE) ? dec_q : dig_code;
    end

    // Next-state logic: handshake, digit stepping and result capture.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        dec_d       = dec_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Flipping both sign bits maps two's-complement order onto unsigned order.
                    a_d            = A;
                    b_d            = B;
                    a_d[WIDTH-1]   = A[WIDTH-1] ^ signed_mode;
                    b_d[WIDTH-1]   = B[WIDTH-1] ^ signed_mode;
                    idx_d          = IDX_MSB;
                    dec_d          = CMP_NONE;
                    state_d        = RUN;
                end
            end
            RUN: begin
                if (((EARLY_EXIT != 0) && (decided != CMP_NONE)) || (idx_q == '0)) begin
                    res_d       = (decided == CMP_NONE) ? CMP_EQ : decided;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                    dec_d = decided;
                end
            end
            DONE: begin
                if (out_ready) begin
                    res_d       = CMP_NONE;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            dec_q       <= CMP_NONE;
            res_q       <= CMP_NONE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            dec_q       <= dec_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign less      = (res_q == CMP_LT);
    assign equal     = (res_q == CMP_EQ);
    assign greater   = (res_q == CMP_GT);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench: two instances (early exit on / off) share operands.
module tb_serial_magnitude_comparator;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    localparam logic [2:0] F_LT = 3'b100;
    localparam logic [2:0] F_EQ = 3'b010;
    localparam logic [2:0] F_GT = 3'b001;

    typedef struct {
        logic [2:0] flags;
        int         cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             sm_in = 1'b0;
    logic             out_ready = 1'b1;
    logic [1:0]       iv = '0;
    logic [1:0]       rdy, ov, lt, eq, gt, bsy;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int or_mode = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy[0]),
        .A(a_in), .B(b_in), .signed_mode(sm_in),
        .out_valid(ov[0]), .out_ready(out_ready),
        .less(lt[0]), .equal(eq[0]), .greater(gt[0]), .busy(bsy[0])
    );

    serial_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(0)) u_full (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy[1]),
        .A(a_in), .B(b_in), .signed_mode(sm_in),
        .out_valid(ov[1]), .out_ready(out_ready),
        .less(lt[1]), .equal(eq[1]), .greater(gt[1]), .busy(bsy[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: flags from the language's own compare, latency from the top differing bit.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sm, input bit ee, input int base);
        exp_t r;
        logic [WIDTH-1:0] diff;
        int k;
        if (sm) r.flags = ($signed(a) < $signed(b)) ? F_LT : (($signed(a) > $signed(b)) ? F_GT : F_EQ);
        else    r.flags = (a < b) ? F_LT : ((a > b) ? F_GT : F_EQ);
        diff = a ^ b;
        k = NDIG;
        if (ee && diff != '0) begin
            for (int i = 0; i < WIDTH; i++) if (diff[i]) k = NDIG - (i / DIGIT);
        end
        r.cyc = base + k;
        return r;
    endfunction

    // out_ready policy: 0 always ready, 1 random, 2 held low.
    initial forever begin
        @(posedge clk); #1;
        case (or_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Issue one pair to both instances; expected results use hand-computed flags/latency.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm,
                        input logic [2:0] flags, input int k_ee, input bit use_model);
        bit pend0 = 1, pend1 = 1, drop0 = 0, drop1 = 0;
        int n = 0;
        exp_t e;
        a_in = a; b_in = b; sm_in = sm; iv = 2'b11;
        while (pend0 || pend1) begin
            if (pend0 && rdy[0]) begin
                if (use_model) e = model(a, b, sm, 1'b1, cyc + 1);
                else begin e.flags = flags; e.cyc = cyc + 1 + k_ee; end
                q0.push_back(e); pend0 = 0; drop0 = 1;
            end
            if (pend1 && rdy[1]) begin
                if (use_model) e = model(a, b, sm, 1'b0, cyc + 1);
                else begin e.flags = flags; e.cyc = cyc + 1 + NDIG; end
                q1.push_back(e); pend1 = 0; drop1 = 1;
            end
            @(posedge clk); #1;
            if (drop0) iv[0] = 1'b0;
            if (drop1) iv[1] = 1'b0;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                iv = '0;
                break;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || ov != '0) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_timeout", int'(n < 500), 1);
    endtask

    // Monitor: pops on each rising out_valid, checks hold/stability and idle flags.
    initial begin
        logic [1:0] pov = '0;
        logic [1:0] phs = '0;
        logic [2:0] pfl [2];
        exp_t e;
        pfl[0] = '0; pfl[1] = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pov = '0; phs = '0;
                continue;
            end
            for (int i = 0; i < 2; i++) begin
                logic [2:0] fl;
                fl = {lt[i], eq[i], gt[i]};
                if (ov[i]) begin
                    if (!pov[i]) begin
                        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                            chk($sformatf("unexpected_result_%0d", i), 1, 0);
                        end else begin
                            e = (i == 0) ? q0.pop_front() : q1.pop_front();
                            chk($sformatf("flags_%0d", i), int'(fl), int'(e.flags));
                            chk($sformatf("latency_%0d", i), cyc, e.cyc);
                        end
                    end else if (!phs[i]) begin
                        chk($sformatf("hold_flags_%0d", i), int'(fl), int'(pfl[i]));
                    end
                    chk($sformatf("in_ready_in_done_%0d", i), int'(rdy[i]), 0);
                end else begin
                    chk($sformatf("idle_flags_%0d", i), int'(fl), 0);
                    if (phs[i]) chk($sformatf("ready_after_take_%0d", i), int'(rdy[i]), 1);
                end
                pov[i] = ov[i];
                pfl[i] = fl;
                phs[i] = ov[i] & out_ready;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with in_valid high: nothing accepted.
        iv = 2'b11;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_out_valid", int'(ov), 0);
            chk("rst_busy", int'(bsy), 0);
        end
        iv = 2'b00;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", int'(rdy), 3);
        chk("post_rst_out_valid", int'(ov), 0);
        chk("post_rst_flags", int'({lt, eq, gt}), 0);

        // Directed vectors: flags and early-exit latency worked out by hand.
        send(16'h1234, 16'h1234, 1'b0, F_EQ, 4, 0);
        @(posedge clk); #1;
        chk("busy_running", int'(bsy), 3);
        drain();
        send(16'h8000, 16'h7FFF, 1'b0, F_GT, 1, 0);
        send(16'h8000, 16'h7FFF, 1'b1, F_LT, 1, 0);
        send(16'h00F0, 16'h00F1, 1'b0, F_LT, 4, 0);
        send(16'hF000, 16'h0000, 1'b0, F_GT, 1, 0);
        send(16'hF000, 16'h0000, 1'b1, F_LT, 1, 0);
        send(16'hFFFF, 16'hFFFE, 1'b1, F_GT, 4, 0);
        send(16'h0000, 16'hFFFF, 1'b1, F_GT, 1, 0);
        send(16'h0120, 16'h0130, 1'b0, F_LT, 3, 0);
        send(16'hABCD, 16'hAB0D, 1'b1, F_GT, 3, 0);
        send(16'h7FFF, 16'h8000, 1'b1, F_GT, 1, 0);
        send(16'h0005, 16'h0003, 1'b0, F_GT, 4, 0);
        drain();

        // Back-pressure: results held, in_valid high while DONE is ignored.
        or_mode = 2;
        @(posedge clk); #1;
        send(16'h00F0, 16'h00F1, 1'b0, F_LT, 4, 0);
        a_in = 16'h0001; b_in = 16'h0002; iv = 2'b11;
        repeat (NDIG + 5) @(posedge clk);
        #1;
        chk("held_valid", int'(ov), 3);
        iv = 2'b00;
        or_mode = 0;
        drain();

        // Reset mid-RUN: no result may ever appear.
        send(16'hFFFF, 16'hFFFE, 1'b0, F_GT, 4, 0);
        void'(q0.pop_back());
        void'(q1.pop_back());
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", int'(bsy), 0);
        chk("abort_in_ready", int'(rdy), 3);
        reset = 1'b0;
        repeat (NDIG + 3) begin
            @(posedge clk); #1;
            chk("abort_no_valid", int'(ov), 0);
        end

        // Randomised pairs checked against the behavioural model.
        or_mode = 1;
        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = (i % 4 == 0) ? ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1)) : WIDTH'($urandom);
            if (i % 7 == 0) rb = ra;
            send(ra, rb, 1'($urandom_range(0, 1)), F_EQ, 0, 1);
        end
        or_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
